datapath_core: RTL and testbench

//  Register/bus datapath driven by the processor control FSM: PC, AR, IR, AC, R, R1-R4 on one shared bus.

---
 rtl/datapath_core_pkg.sv | 60 ++++++
 rtl/datapath_core_alu.sv | 24 ++
 rtl/datapath_core.sv | 128 ++++++++++++
 tb/tb_datapath_core.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_core_pkg.sv
// Shared encodings for the processor datapath: bus source codes, strobe bit
// indices and ALU opcodes. The control FSM imports the same package.
package datapath_core_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int STRB_W     = 16;

  typedef enum logic [3:0] {
    SRC_NONE = 4'd0,
    SRC_PC   = 4'd1,
    SRC_AR   = 4'd2,
    SRC_IR   = 4'd4,
    SRC_AC   = 4'd5,
    SRC_R    = 4'd6,
    SRC_R1   = 4'd7,
    SRC_R2   = 4'd8,
    SRC_R3   = 4'd9,
    SRC_R4   = 4'd10,
    SRC_DM   = 4'd12,
    SRC_IM   = 4'd13
  } src_e;

  localparam int WB_PC     = 1;
  localparam int WB_AR     = 2;
  localparam int WB_IR     = 3;
  localparam int WB_AC     = 4;
  localparam int WB_R      = 5;
  localparam int WB_R4     = 7;
  localparam int WB_R3     = 8;
  localparam int WB_R2     = 9;
  localparam int WB_R1     = 10;
  localparam int WB_DM     = 11;
  localparam int WB_ALU_AC = 12;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_MUL  = 3'd3,
    ALU_LSH  = 3'd4
  } alu_op_e;

  // Per-register update request as seen by the counting registers (PC, AR, AC).
  typedef struct packed {
    logic clr;
    logic ld;
    logic inc;
  } strb_t;

  function automatic strb_t get_strb(logic [STRB_W-1:0] we, logic [STRB_W-1:0] inc,
                                     logic [STRB_W-1:0] clr, int idx);
    strb_t s;
    s.clr = clr[idx];
    s.ld  = we[idx];
    s.inc = inc[idx];
    return s;
  endfunction

endpackage

// File: rtl/datapath_core_alu.sv
// Combinational ALU on AC and R; results wrap to DATA_W bits, no flags.
module alu_unit
  import datapath_core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] ac_i,
  input  logic [DATA_W-1:0] r_i,
  input  logic [2:0]        alu_op_i,
  output logic [DATA_W-1:0] res_o
);

  always_comb begin
    res_o = ac_i;
    case (alu_op_i)
      ALU_ADD: res_o = ac_i + r_i;
      ALU_SUB: res_o = ac_i - r_i;
      ALU_MUL: res_o = ac_i * r_i;
      ALU_LSH: res_o = {ac_i[DATA_W-2:0], 1'b0};
      default: res_o = ac_i;
    endcase
  end

endmodule

// File: rtl/datapath_core.sv
// Register/bus datapath: PC, AR, IR, AC, R, R1-R4 sharing one bus, driven by
// the control FSM's read select and per-register strobes.
module datapath_core
  import datapath_core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        read_en,
  input  logic [15:0]       write_en,
  input  logic [15:0]       inc_en,
  input  logic [15:0]       clr_en,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] im_rdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] im_addr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic [5:0]        instruction,
  output logic [15:0]       z,
  output logic [DATA_W-1:0] bus
);

  logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
  logic [DATA_W-1:0] ir_q, ir_d, ac_q, ac_d, r_q, r_d;
  logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, r4_q, r4_d;
  logic [DATA_W-1:0] alu_res;
  strb_t             pc_s, ar_s, ac_s;

  alu_unit #(.DATA_W(DATA_W)) u_alu (
    .ac_i     (ac_q),
    .r_i      (r_q),
    .alu_op_i (alu_op),
    .res_o    (alu_res)
  );

  always_comb begin
    bus = '0;
    case (read_en)
      SRC_PC:  bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      SRC_AR:  bus = {{(DATA_W-ADDR_W){1'b0}}, ar_q};
      SRC_IR:  bus = ir_q;
      SRC_AC:  bus = ac_q;
      SRC_R:   bus = r_q;
      SRC_R1:  bus = r1_q;
      SRC_R2:  bus = r2_q;
      SRC_R3:  bus = r3_q;
      SRC_R4:  bus = r4_q;
      SRC_DM:  bus = dm_rdata;
      SRC_IM:  bus = im_rdata;
      default: bus = '0;
    endcase
  end

  assign pc_s = get_strb(write_en, inc_en, clr_en, WB_PC);
  assign ar_s = get_strb(write_en, inc_en, clr_en, WB_AR);
  assign ac_s = get_strb(write_en, inc_en, clr_en, WB_AC);

  // Counting registers: clear beats load beats increment.
  always_comb begin
    pc_d = pc_q;
    if (pc_s.clr)      pc_d = '0;
    else if (pc_s.ld)  pc_d = bus[ADDR_W-1:0];
    else if (pc_s.inc) pc_d = pc_q + ADDR_W'(1);

    ar_d = ar_q;
    if (ar_s.clr)      ar_d = '0;
    else if (ar_s.ld)  ar_d = bus[ADDR_W-1:0];
    else if (ar_s.inc) ar_d = ar_q + ADDR_W'(1);

    // AC has two load sources; the ALU path wins over the bus.
    ac_d = ac_q;
    if (ac_s.clr)                    ac_d = '0;
    else if (write_en[WB_ALU_AC])    ac_d = alu_res;
    else if (ac_s.ld)                ac_d = bus;
    else if (ac_s.inc)               ac_d = ac_q + DATA_W'(1);
  end

  always_comb begin
    ir_d = write_en[WB_IR] ? bus : ir_q;
    r_d  = write_en[WB_R]  ? bus : r_q;
    r1_d = write_en[WB_R1] ? bus : r1_q;
    r2_d = write_en[WB_R2] ? bus : r2_q;
    r3_d = write_en[WB_R3] ? bus : r3_q;
    r4_d = write_en[WB_R4] ? bus : r4_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      ar_q <= '0;
      ir_q <= '0;
      ac_q <= '0;
      r_q  <= '0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      r4_q <= '0;
    end else begin
      pc_q <= pc_d;
      ar_q <= ar_d;
      ir_q <= ir_d;
      ac_q <= ac_d;
      r_q  <= r_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
      r4_q <= r4_d;
    end
  end

  assign im_addr     = pc_q;
  assign dm_addr     = ar_q;
  assign dm_wdata    = bus;
  assign dm_we       = write_en[WB_DM];
  assign instruction = ir_q[5:0];
  assign z           = {15'b0, (ac_q == '0)};

  // Strobe bits with no destination, and inc/clr on load-only registers.
  logic unused_strb;
  assign unused_strb = ^{write_en[15:13], write_en[6], write_en[0],
                         inc_en[15:5], inc_en[3], inc_en[0],
                         clr_en[15:5], clr_en[3], clr_en[0]};

endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core: a register-level reference model checked
// every negedge, plus literal expectations from hand-worked instruction steps.
module tb_datapath_core;

  logic        clk, rst_n;
  logic [3:0]  read_en;
  logic [15:0] write_en, inc_en, clr_en;
  logic [2:0]  alu_op;
  logic [15:0] im_rdata, dm_rdata;
  logic [7:0]  im_addr, dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_we;
  logic [5:0]  instruction;
  logic [15:0] z, bus;

  int checks = 0;
  int errors = 0;

  datapath_core dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
    .inc_en(inc_en), .clr_en(clr_en), .alu_op(alu_op),
    .im_rdata(im_rdata), .dm_rdata(dm_rdata), .im_addr(im_addr),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .instruction(instruction), .z(z), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_pc, m_ar;
  logic [15:0] m_ir, m_ac, m_r, m_rn [1:4];

  function automatic logic [15:0] m_bus();
    case (read_en)
      4'd1:    return {8'h00, m_pc};
      4'd2:    return {8'h00, m_ar};
      4'd4:    return m_ir;
      4'd5:    return m_ac;
      4'd6:    return m_r;
      4'd7:    return m_rn[1];
      4'd8:    return m_rn[2];
      4'd9:    return m_rn[3];
      4'd10:   return m_rn[4];
      4'd12:   return dm_rdata;
      4'd13:   return im_rdata;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] m_alu();
    longint a = longint'(m_ac);
    longint b = longint'(m_r);
    longint res;
    case (alu_op)
      3'd1:    res = a + b;
      3'd2:    res = a - b;
      3'd3:    res = a * b;
      3'd4:    res = a * 2;
      default: res = a;
    endcase
    return res[15:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] b, al;
    if (!rst_n) begin
      m_pc = 0; m_ar = 0; m_ir = 0; m_ac = 0; m_r = 0;
      for (int k = 1; k <= 4; k++) m_rn[k] = 0;
    end else begin
      b  = m_bus();
      al = m_alu();
      if (clr_en[1]) m_pc = 0;
      else if (write_en[1]) m_pc = b[7:0];
      else if (inc_en[1]) m_pc = 8'((int'(m_pc) + 1) % 256);
      if (clr_en[2]) m_ar = 0;
      else if (write_en[2]) m_ar = b[7:0];
      else if (inc_en[2]) m_ar = 8'((int'(m_ar) + 1) % 256);
      if (clr_en[4]) m_ac = 0;
      else if (write_en[12]) m_ac = al;
      else if (write_en[4]) m_ac = b;
      else if (inc_en[4]) m_ac = 16'((int'(m_ac) + 1) % 65536);
      if (write_en[3])  m_ir    = b;
      if (write_en[5])  m_r     = b;
      if (write_en[10]) m_rn[1] = b;
      if (write_en[9])  m_rn[2] = b;
      if (write_en[8])  m_rn[3] = b;
      if (write_en[7])  m_rn[4] = b;
    end
  end

  always @(negedge clk) begin
    check("cmp_bus",   bus,         m_bus());
    check("cmp_wdata", dm_wdata,    m_bus());
    check("cmp_imadr", im_addr,     m_pc);
    check("cmp_dmadr", dm_addr,     m_ar);
    check("cmp_dmwe",  dm_we,       write_en[11]);
    check("cmp_instr", instruction, m_ir[5:0]);
    check("cmp_z",     z,           (m_ac == 0) ? 16'h0001 : 16'h0000);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] B(input int n);
    return 16'h0001 << n;
  endfunction

  task automatic idle();
    read_en = 0; write_en = 0; inc_en = 0; clr_en = 0; alu_op = 0;
  endtask

  task automatic cyc(input logic [3:0] rd, input logic [15:0] we, input logic [15:0] inc,
                     input logic [15:0] clr, input logic [2:0] op);
    read_en = rd; write_en = we; inc_en = inc; clr_en = clr; alu_op = op;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic ld_dm(input logic [15:0] v, input logic [15:0] we);
    dm_rdata = v;
    cyc(4'd12, we, 16'h0, 16'h0, 3'd0);
  endtask

  task automatic ld_im(input logic [15:0] v, input logic [15:0] we);
    im_rdata = v;
    cyc(4'd13, we, 16'h0, 16'h0, 3'd0);
  endtask

  task automatic peek(input logic [3:0] rd, input string nm, input logic [15:0] exp);
    read_en = rd;
    #1 check(nm, bus, exp);
    read_en = 0;
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; idle(); im_rdata = 0; dm_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    write_en = B(11);
    #1;
    check("rst_dmwe", dm_we, 1'b1);
    check("rst_z", z, 16'h0001);
    check("rst_imadr", im_addr, 8'h00);
    check("rst_instr", instruction, 6'h00);
    dm_rdata = 16'hBEEF; read_en = 12;
    write_en = 16'hFFFF; inc_en = 16'hFFFF;
    @(posedge clk); #1;
    idle();
    peek(5, "rst_hold_ac", 16'h0000);
    peek(1, "rst_hold_pc", 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: async reset mid-instruction
    ld_dm(16'h1234, B(4));
    ld_im(16'h0005, B(1));
    check("t1_pc", im_addr, 8'h05);
    peek(5, "t1_ac", 16'h1234);
    read_en = 5;
    rst_n = 1'b0;
    #1;
    check("t1_rst_ac", bus, 16'h0000);
    check("t1_rst_z", z, 16'h0001);
    check("t1_rst_pc", im_addr, 8'h00);
    rst_n = 1'b1;
    read_en = 0;
    @(posedge clk); #1;

    // 2: fetch
    ld_im(16'h0003, B(1));
    check("t2_pc3", im_addr, 8'h03);
    im_rdata = 16'h0013;
    cyc(13, B(3), 0, 0, 0);
    check("t2_instr", instruction, 6'h13);
    peek(4, "t2_ir", 16'h0013);
    cyc(0, 0, B(1), 0, 0);
    check("t2_pc4", im_addr, 8'h04);

    // 3: ALU
    ld_dm(16'h0005, B(4));
    ld_dm(16'h0007, B(5));
    cyc(0, B(12), 0, 0, 3'd2);
    peek(5, "t3_sub", 16'hFFFE);
    check("t3_z", z, 16'h0000);
    ld_dm(16'h0002, B(5));
    cyc(0, B(12), 0, 0, 3'd3);
    peek(5, "t3_mul", 16'hFFFC);
    cyc(0, B(12), 0, 0, 3'd4);
    peek(5, "t3_lsh", 16'hFFF8);
    cyc(0, B(12), 0, 0, 3'd1);
    peek(5, "t3_add", 16'hFFFA);
    cyc(0, B(12), 0, 0, 3'd6);
    peek(5, "t3_op6", 16'hFFFA);
    cyc(0, B(12), 0, 0, 3'd0);
    peek(5, "t3_op0", 16'hFFFA);
    ld_dm(16'h1234, B(4));
    ld_dm(16'h0100, B(5));
    cyc(0, B(12), 0, 0, 3'd3);
    peek(5, "t3_mulwrap", 16'h3400);

    // 4: priority
    cyc(0, B(12), B(4), B(4), 3'd1);
    peek(5, "t4_clr", 16'h0000);
    ld_dm(16'h0010, B(4));
    ld_dm(16'h0001, B(5));
    dm_rdata = 16'h00AA;
    cyc(12, B(12) | B(4), 0, 0, 3'd1);
    peek(5, "t4_alu_over_bus", 16'h0011);
    dm_rdata = 16'h0050;
    cyc(12, B(4), B(4), 0, 0);
    peek(5, "t4_ld_over_inc", 16'h0050);
    im_rdata = 16'h0077;
    cyc(13, B(1), 0, B(1), 0);
    check("t4_pc_clr", im_addr, 8'h00);
    cyc(13, B(1), B(1), 0, 0);
    check("t4_pc_ld", im_addr, 8'h77);

    // 5: wrap
    ld_im(16'h00FF, B(1));
    cyc(0, 0, B(1), 0, 0);
    check("t5_pc_wrap", im_addr, 8'h00);
    ld_dm(16'hFFFF, B(4));
    check("t5_z0", z, 16'h0000);
    cyc(0, 0, B(4), 0, 0);
    check("t5_z1", z, 16'h0001);
    peek(5, "t5_ac_wrap", 16'h0000);
    ld_dm(16'h00FF, B(2));
    check("t5_ar_ff", dm_addr, 8'hFF);
    cyc(0, 0, B(2), 0, 0);
    check("t5_ar_wrap", dm_addr, 8'h00);
    ld_dm(16'hAB12, B(2));
    peek(2, "t5_ar_trunc", 16'h0012);

    // 6: store / move
    ld_dm(16'h0042, B(4));
    ld_dm(16'h0010, B(2));
    read_en = 5; write_en = B(11);
    #1;
    check("t6_dmwe", dm_we, 1'b1);
    check("t6_wdata", dm_wdata, 16'h0042);
    check("t6_dmadr", dm_addr, 8'h10);
    @(posedge clk); #1;
    idle();
    cyc(5, B(10), 0, 0, 0);
    peek(7, "t6_r1", 16'h0042);
    peek(11, "t6_code11", 16'h0000);
    ld_dm(16'h0222, B(9));
    ld_dm(16'h0333, B(8));
    ld_dm(16'h0444, B(7));
    peek(8, "t6_r2", 16'h0222);
    peek(9, "t6_r3", 16'h0333);
    peek(10, "t6_r4", 16'h0444);
    peek(6, "t6_r", 16'h0001);
    peek(1, "t6_pc", 16'h0000);
    peek(3, "t6_code3", 16'h0000);
    peek(14, "t6_code14", 16'h0000);
    peek(15, "t6_code15", 16'h0000);

    // ignored strobe bits and inc/clr on load-only registers
    dm_rdata = 16'hDEAD;
    cyc(12, B(0) | B(6) | B(13) | B(14) | B(15), B(5) | B(3) | B(7), B(5) | B(3) | B(10), 0);
    peek(6, "ign_r", 16'h0001);
    peek(7, "ign_r1", 16'h0042);
    peek(4, "ign_ir", 16'h0013);
    peek(5, "ign_ac", 16'h0042);
    peek(10, "ign_r4", 16'h0444);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
